// File: rtl/face_pkg.sv
`default_nettype none
// ============================================================================
// Module      : face_pkg
// Description : Shared widths, defaults and FSM encoding for the integral
//               image generator and its line buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package face_pkg;

    localparam int DEF_MAX_WIDTH = 768;   // 3*(2048/8)
    localparam int DEF_PIX_W     = 8;
    localparam int DEF_SUM_W     = 32;
    localparam int DEF_DIM_W     = 16;
    localparam int DEF_ADDR_W    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    function automatic logic size_ok(input logic [DEF_DIM_W-1:0] w,
                                     input logic [DEF_DIM_W-1:0] h,
                                     input int                   max_w);
        return (w != '0) && (h != '0) && (int'(w) <= max_w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/integral_image_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : integral_image_gen_if
// Description : Control, pixel-input and integral-output signals of the
//               integral image generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface integral_image_gen_if
    import face_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int SUM_W  = DEF_SUM_W,
    parameter int DIM_W  = DEF_DIM_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();
    logic              start;
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
    logic              in_valid;
    logic              in_ready;
    logic [PIX_W-1:0]  in_pixel;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic [ADDR_W-1:0] out_addr;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, width, height, in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_sum, out_addr, busy, done, err
    );

    modport slave (
        input  start, width, height, in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_sum, out_addr, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/integral_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : integral_line_buf
// Description : One row of integral values; asynchronous read, synchronous
//               write, read-before-write on an address collision.
// Revision    : 1.0 - initial release
// ============================================================================
module integral_line_buf
    import face_pkg::*;
#(
    parameter  int DEPTH  = DEF_MAX_WIDTH,
    parameter  int DATA_W = DEF_SUM_W,
    localparam int AW     = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [AW-1:0]     wr_addr,
    input  wire logic [DATA_W-1:0] wr_data,
    input  wire logic [AW-1:0]     rd_addr,
    output      logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Combinational read sees the pre-edge contents even when we hits rd_addr.
    assign rd_data = r_mem[rd_addr];
endmodule
`default_nettype wire

// File: rtl/integral_image_gen.sv
`default_nettype none
// ============================================================================
// Module      : integral_image_gen
// Description : Streaming summed-area table builder: raster pixels in,
//               I(x,y) plus linear address out, one output register deep.
// Revision    : 1.0 - initial release
// ============================================================================
module integral_image_gen
    import face_pkg::*;
#(
    parameter int MAX_WIDTH = DEF_MAX_WIDTH,
    parameter int PIX_W     = DEF_PIX_W,
    parameter int SUM_W     = DEF_SUM_W,
    parameter int DIM_W     = DEF_DIM_W
) (
    input wire logic           clk,
    input wire logic           reset,
    integral_image_gen_if.slave bus
);
    localparam int LB_AW = $clog2(MAX_WIDTH);

    state_t           r_state, w_state_n;
    logic [DIM_W-1:0] r_width, r_height, r_x, r_y;
    logic [SUM_W-1:0] r_row_sum, r_out_sum;
    logic [31:0]      r_addr, r_out_addr;
    logic             r_out_valid, r_busy;

    logic             w_in_ready, w_accept, w_start_ok, w_done, w_err;
    logic             w_x_wrap, w_last;
    logic [PIX_W-1:0] w_pixel;
    logic [SUM_W-1:0] w_row_sum_n, w_above, w_sum, w_lb_rd;

    assign w_pixel     = bus.in_pixel;
    assign w_x_wrap    = (r_x == r_width - DIM_W'(1));
    assign w_last      = w_x_wrap && (r_y == r_height - DIM_W'(1));
    assign w_row_sum_n = ((r_x == '0) ? '0 : r_row_sum) + SUM_W'(w_pixel);
    assign w_above     = (r_y == '0) ? '0 : w_lb_rd;
    assign w_sum       = w_row_sum_n + w_above;
    assign w_accept    = w_in_ready && bus.in_valid;

    always_comb begin
        w_state_n  = r_state;
        w_in_ready = 1'b0;
        w_start_ok = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (size_ok(bus.width, bus.height, MAX_WIDTH)) begin
                        w_start_ok = 1'b1;
                        w_state_n  = RUN;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            RUN: begin
                w_in_ready = !r_out_valid || bus.out_ready;
                if (w_in_ready && bus.in_valid && w_last) begin
                    w_state_n = FLUSH;
                end
            end
            FLUSH: begin
                if (r_out_valid && bus.out_ready) begin
                    w_done    = 1'b1;
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_width     <= '0;
            r_height    <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_row_sum   <= '0;
            r_addr      <= '0;
            r_out_sum   <= '0;
            r_out_addr  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_start_ok) begin
                r_width   <= bus.width;
                r_height  <= bus.height;
                r_x       <= '0;
                r_y       <= '0;
                r_row_sum <= '0;
                r_addr    <= '0;
                r_busy    <= 1'b1;
            end
            if (w_accept) begin
                r_row_sum   <= w_row_sum_n;
                r_out_sum   <= w_sum;
                r_out_addr  <= r_addr;
                r_out_valid <= 1'b1;
                r_addr      <= r_addr + 32'd1;
                if (w_x_wrap) begin
                    r_x <= '0;
                    r_y <= r_y + DIM_W'(1);
                end else begin
                    r_x <= r_x + DIM_W'(1);
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    integral_line_buf #(
        .DEPTH  (MAX_WIDTH),
        .DATA_W (SUM_W)
    ) u_line_buf (
        .clk     (clk),
        .we      (w_accept),
        .wr_addr (r_x[LB_AW-1:0]),
        .wr_data (w_sum),
        .rd_addr (r_x[LB_AW-1:0]),
        .rd_data (w_lb_rd)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_addr  = r_out_addr;
    assign bus.busy      = r_busy;
    assign bus.done      = w_done;
    assign bus.err       = w_err;
endmodule
`default_nettype wire

// File: tb/tb_integral_image_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_integral_image_gen
// Description : Directed self-checking bench for integral_image_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_integral_image_gen;
    import face_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    integral_image_gen_if bus ();

    integral_image_gen #(
        .MAX_WIDTH (DEF_MAX_WIDTH),
        .PIX_W     (DEF_PIX_W),
        .SUM_W     (DEF_SUM_W),
        .DIM_W     (DEF_DIM_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int err_cnt = 0;
    int done_cnt = 0;

    int          pix[$];
    logic [31:0] exp_sum_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] got_q[$];
    logic [31:0] lit_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    // Reference: I(x,y) as a plain double sum over the rectangle (0,0)..(x,y).
    task automatic load_model(input int w, input int h);
        logic [31:0] s;
        exp_sum_q.delete();
        exp_addr_q.delete();
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                s = 0;
                for (int j = 0; j <= y; j++)
                    for (int i = 0; i <= x; i++)
                        s += 32'(pix[j*w + i]);
                exp_sum_q.push_back(s);
                exp_addr_q.push_back(32'(y*w + x));
            end
        end
    endtask

    task automatic check_lits(input string name);
        check({name, "_count"}, 64'(got_q.size()), 64'(lit_q.size()));
        for (int i = 0; i < lit_q.size() && i < got_q.size(); i++)
            check(name, 64'(got_q[i]), 64'(lit_q[i]));
    endtask

    logic        prev_stall = 1'b0;
    logic [31:0] held_sum, held_addr;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.err) err_cnt++;
            if (prev_stall) begin
                check("hold_sum", 64'(bus.out_sum), 64'(held_sum));
                check("hold_addr", 64'(bus.out_addr), 64'(held_addr));
            end
            if (bus.out_valid && !bus.out_ready)
                check("in_ready_stalled", 64'(bus.in_ready), 64'd0);
            if (bus.out_valid && bus.out_ready) begin
                check("exp_available", 64'(exp_sum_q.size() != 0), 64'd1);
                if (exp_sum_q.size() != 0) begin
                    check("out_sum", 64'(bus.out_sum), 64'(exp_sum_q.pop_front()));
                    check("out_addr", 64'(bus.out_addr), 64'(exp_addr_q.pop_front()));
                    got_q.push_back(bus.out_sum);
                end
            end
            if (bus.done) begin
                done_cnt++;
                check("done_on_fire", 64'(bus.out_valid && bus.out_ready), 64'd1);
                check("done_last", 64'(exp_sum_q.size()), 64'd0);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            held_sum   = bus.out_sum;
            held_addr  = bus.out_addr;
        end
    end

    task automatic check_idle_zero(input string name);
        check({name, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({name, "_busy"}, 64'(bus.busy), 64'd0);
        check({name, "_done"}, 64'(bus.done), 64'd0);
        check({name, "_err"}, 64'(bus.err), 64'd0);
        check({name, "_out_sum"}, 64'(bus.out_sum), 64'd0);
        check({name, "_out_addr"}, 64'(bus.out_addr), 64'd0);
    endtask

    // Runs one frame from pix[]; optional output stall and mid-frame start.
    task automatic run_frame(input int w, input int h, input int stall, input int restart_at);
        int k, stall_left;
        bit acc, fin, sent;
        load_model(w, h);
        got_q.delete();
        @(posedge clk); #1;
        bus.start = 1'b1; bus.width = 16'(w); bus.height = 16'(h);
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0; stall_left = stall; fin = 0; sent = 0;
        bus.in_valid = 1'b1; bus.in_pixel = 8'(pix[0]); bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 0) check("busy_after_start", 64'(bus.busy), 64'd1);
            acc = bus.in_valid && bus.in_ready;
            fin = bus.done;
            @(posedge clk); #1;
            if (acc) begin
                k++;
                if (k < w*h) bus.in_pixel = 8'(pix[k]);
                else         bus.in_valid = 1'b0;
            end
            if (stall_left > 0 && bus.out_valid) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (restart_at >= 0 && k == restart_at && !sent) begin
                bus.start = 1'b1; bus.width = 16'd5; bus.height = 16'd1; sent = 1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("frame_done_seen", 64'(fin), 64'd1);
        check("frame_out_count", 64'(got_q.size()), 64'(w*h));
        @(negedge clk);
        check("busy_after_done", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int err_before, k;
        bit acc;
        bus.start = 1'b0; bus.width = '0; bus.height = '0;
        bus.in_valid = 1'b0; bus.in_pixel = '0; bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk); #1; reset = 1'b1;

        // 3x3 of ones
        pix = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        run_frame(3, 3, 0, -1);
        lit_q = '{1, 2, 3, 2, 4, 6, 3, 6, 9};
        check_lits("ones3x3");

        // 2x2 with a 3-cycle output stall
        pix = '{1, 2, 3, 4};
        run_frame(2, 2, 3, -1);
        lit_q = '{1, 3, 4, 10};
        check_lits("stall2x2");

        // rejected sizes
        err_before = err_cnt;
        @(posedge clk); #1; bus.start = 1'b1; bus.width = 16'd0; bus.height = 16'd3;
        @(negedge clk);
        check("err_w0", 64'(bus.err), 64'd1);
        @(posedge clk); #1; bus.start = 1'b0;
        @(negedge clk);
        check("err_w0_pulse", 64'(bus.err), 64'd0);
        check("err_w0_busy", 64'(bus.busy), 64'd0);
        @(posedge clk); #1; bus.start = 1'b1; bus.width = 16'(DEF_MAX_WIDTH + 1); bus.height = 16'd2;
        @(negedge clk);
        check("err_wmax", 64'(bus.err), 64'd1);
        check("err_wmax_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1; bus.start = 1'b0;
        @(negedge clk);
        check("err_wmax_busy", 64'(bus.busy), 64'd0);
        check("err_wmax_in_ready2", 64'(bus.in_ready), 64'd0);
        check("err_pulses", 64'(err_cnt - err_before), 64'd2);

        // abort after two pixels
        pix = '{7, 9, 11, 13};
        load_model(2, 2);
        @(posedge clk); #1; bus.start = 1'b1; bus.width = 16'd2; bus.height = 16'd2;
        @(posedge clk); #1; bus.start = 1'b0;
        k = 0; bus.in_valid = 1'b1; bus.in_pixel = 8'(pix[0]); bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && k < 2; cyc++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) begin k++; bus.in_pixel = 8'(pix[k]); end
        end
        check("abort_pixels_accepted", 64'(k), 64'd2);
        reset = 1'b0; bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_zero("abort");
        exp_sum_q.delete(); exp_addr_q.delete();
        @(posedge clk); #1; reset = 1'b1;

        pix = '{255, 255, 255, 255};
        run_frame(2, 2, 0, -1);
        lit_q = '{255, 510, 510, 1020};
        check_lits("after_abort");

        // start during RUN is ignored
        err_before = err_cnt;
        pix = '{1, 2, 3, 4, 5, 6};
        run_frame(3, 2, 0, 2);
        lit_q = '{1, 3, 6, 5, 12, 21};
        check_lits("restart_ignored");
        check("restart_no_err", 64'(err_cnt - err_before), 64'd0);

        // single-column frame
        pix = '{10, 20, 30, 40};
        run_frame(1, 4, 0, -1);
        lit_q = '{10, 30, 60, 100};
        check_lits("width1");

        check("done_total", 64'(done_cnt), 64'd5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/integral_image_gen.md
Name: integral_image_gen

Overview:
Streaming builder of the summed-area (integral) image that each face-detection core consumes as its image[] array. Raster-ordered 8-bit grey pixels go in. For each pixel the block emits I(x,y) = sum of all pixels p(i,j) with i<=x and j<=y, together with the linear word address y*width+x. Downstream logic or a testbench writes the stream into a core's image memory or into coreNN.txt.

Parameters:
MAX_WIDTH, 768, largest supported row length in pixels; sets line-buffer depth.
PIX_W, 8, input pixel width.
SUM_W, 32, integral output width; arithmetic is modulo 2^SUM_W.
DIM_W, 16, width of the width/height configuration inputs.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle request to begin a frame; sampled only in IDLE
width  in  DIM_W  pixels per row; latched on accepted start
height  in  DIM_W  rows per frame; latched on accepted start
in_valid  in  1  in_pixel is valid
in_ready  out  1  block accepts in_pixel this cycle
in_pixel  in  PIX_W  raster-order pixel, unsigned
out_valid  out  1  out_sum/out_addr valid
out_ready  in  1  downstream accepts output this cycle
out_sum  out  SUM_W  integral value I(x,y)
out_addr  out  32  linear address y*width+x
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the last output is accepted
err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE. in_ready, out_valid, busy, done, err all 0. out_sum=0, out_addr=0, x=y=0, row_sum=0. Line-buffer contents are not cleared; row 0 never reads them.
- States: IDLE, RUN, FLUSH.
- IDLE, start=1, 1<=width<=MAX_WIDTH and height>=1: latch width and height, clear x, y, row_sum and addr, go to RUN, busy=1.
- IDLE, start=1 with an invalid size: err=1 for one cycle, stay IDLE.
- start in RUN or FLUSH is ignored (no err).
- RUN: in_ready = !out_valid || out_ready, giving a single output register with full throughput.
- Accept occurs when in_valid && in_ready. On accept:
  - row_sum_n = (x==0 ? 0 : row_sum) + in_pixel, zero-extended.
  - above = (y==0) ? 0 : lbuf[x].
  - out_sum <= row_sum_n + above (mod 2^SUM_W); out_addr <= addr; out_valid <= 1.
  - lbuf[x] <= row_sum_n + above.
  - addr++. x++; when x==width-1, x<=0 and y++.
- Latency: out_valid rises on the clk edge that accepts the pixel (one cycle).
- out_valid && !out_ready: out_sum and out_addr hold stable. in_ready=0.
- Output accepted (out_valid && out_ready) with no new accept: out_valid <= 0.
- After the last pixel is accepted (x==width-1, y==height-1): go to FLUSH, in_ready=0.
- FLUSH: when the final output is accepted, done=1 for one cycle, busy<=0, out_valid<=0, state=IDLE.
- in_pixel values in IDLE or FLUSH are ignored. in_ready=0 outside RUN.
- Reset mid-frame aborts immediately to the reset values; no done pulse. The next frame is unaffected by stale line-buffer data.
- width==1 is legal: every pixel is x==0, so I = column running sum.

Decomposition:
- Shared package face_pkg: PIX_W, SUM_W, DIM_W defaults; state enum {IDLE, RUN, FLUSH}; MAX_WIDTH default (768 = 3*(size/8) for size 2048).
- Sub-module integral_line_buf: MAX_WIDTH x SUM_W register array, combinational read at rd_addr, synchronous write on we. It must read the old value when reading and writing the same address in one cycle.

Test Plan:
- width=3, height=3, nine pixels of 1, out_ready=1 -> out_sum 1,2,3,2,4,6,3,6,9; out_addr 0..8; done on the 9th accepted output; busy falls on the next cycle.
- width=2, height=2, pixels 1,2,3,4, out_ready held 0 for 3 cycles after the first output -> out_sum=1 is held stable, in_ready=0 throughout; the stream then resumes 1,3,4,10 with no loss or duplication.
- start with width=0, then start with width=MAX_WIDTH+1 -> err pulses once per start; busy stays 0; in_ready stays 0.
- width=2, height=2 frame interrupted by reset after 2 pixels -> all outputs 0. A new frame of four pixels of 255 -> 255,510,510,1020 with no stale contribution.
- start pulsed again mid-frame with width=5 -> ignored; the frame completes with the original width; out_addr sequence is unchanged.
- width=1, height=4, pixels 10,20,30,40 -> 10,30,60,100; out_addr 0..3; done after the 4th output.
